// File: rtl/lsu_mem_port.sv
// lsu_mem_port
// Load/store adapter between the core memory stage and port B of the data RAM.
// One byte/half/word access per request handshake. Sub-word stores are done as
// read-modify-write since the RAM has no byte enables. Load data is lane-aligned
// and sign/zero extended. Misaligned, illegal-size and out-of-range requests get
// an error response without any RAM activity.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   req_*_i / req_ready_o request channel (valid/ready handshake)
//   rsp_*_o / rsp_ready_i response channel (valid held until ready)
//   ram_*_o / ram_rdata_i RAM port B (registered read, data valid next cycle)
module lsu_mem_port #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [31:0]           req_addr_i,
   input  logic [1:0]            req_size_i,
   input  logic                  req_unsigned_i,
   input  logic [31:0]           req_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [31:0]           rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  ram_wr_en_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [31:0]           ram_wdata_o,
   input  logic [31:0]           ram_rdata_i
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DATA   = 2'd2,
      RESP   = 2'd3
   } state_e;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   state_e                state_q, state_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH+1:0] addr_q, addr_d;
   logic [1:0]            size_q, size_d;
   logic                  uns_q, uns_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;

   logic                  reqErr;
   logic [7:0]            byteLane;
   logic [15:0]           halfLane;
   logic [31:0]           loadData;
   logic [31:0]           mergeData;

   // Request error check: any address bit above the RAM range is an error,
   // tested with a shift so the check still works when the RAM fills the map.
   always_comb begin
      reqErr = 1'b0;
      if (req_size_i == 2'b11) begin
         reqErr = 1'b1;
      end
      if ((req_size_i == SIZE_HALF) && req_addr_i[0]) begin
         reqErr = 1'b1;
      end
      if ((req_size_i == SIZE_WORD) && (req_addr_i[1:0] != 2'b00)) begin
         reqErr = 1'b1;
      end
      if ((req_addr_i >> (ADDR_WIDTH + 2)) != 32'd0) begin
         reqErr = 1'b1;
      end
   end

   // Lane extraction/extension for loads and lane merge for sub-word stores,
   // both working on the RAM word returned during DATA.
   always_comb begin
      byteLane  = ram_rdata_i[{addr_q[1:0], 3'b000} +: 8];
      halfLane  = ram_rdata_i[{addr_q[1], 4'b0000} +: 16];
      loadData  = ram_rdata_i;
      mergeData = ram_rdata_i;
      case (size_q)
         SIZE_BYTE: begin
            loadData = {{24{~uns_q & byteLane[7]}}, byteLane};
            mergeData[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         end
         SIZE_HALF: begin
            loadData = {{16{~uns_q & halfLane[15]}}, halfLane};
            mergeData[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         end
         default: begin
            loadData  = ram_rdata_i;
            mergeData = ram_rdata_i;
         end
      endcase
   end

   // Next-state and RAM port control. RAM outputs are driven only in ACCESS and
   // DATA so an abandoned access (reset) can never leave a write pending.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      addr_d      = addr_q;
      size_d      = size_q;
      uns_d       = uns_q;
      wdata_d     = wdata_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      ram_wr_en_o = 1'b0;
      ram_addr_o  = '0;
      ram_wdata_o = 32'd0;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               we_d    = req_we_i;
               addr_d  = req_addr_i[ADDR_WIDTH+1:0];
               size_d  = req_size_i;
               uns_d   = req_unsigned_i;
               wdata_d = req_wdata_i;
               if (reqErr) begin
                  rsp_err_d = 1'b1;
                  state_d   = RESP;
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            ram_addr_o = addr_q[ADDR_WIDTH+1:2];
            if (we_q && (size_q == SIZE_WORD)) begin
               ram_wr_en_o = 1'b1;
               ram_wdata_o = wdata_q;
               state_d     = RESP;
            end else begin
               state_d = DATA;
            end
         end
         DATA: begin
            ram_addr_o = addr_q[ADDR_WIDTH+1:2];
            if (we_q) begin
               ram_wr_en_o = 1'b1;
               ram_wdata_o = mergeData;
            end else begin
               rsp_rdata_d = loadData;
            end
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready_i) begin
               rsp_rdata_d = 32'd0;
               rsp_err_d   = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and captured request registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         wdata_q     <= 32'd0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         wdata_q     <= wdata_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready_o = (state_q == IDLE);
   assign rsp_valid_o = (state_q == RESP);
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule
